// File: rtl/frame_pkg.sv
// Shared constants, types and FSM states for the serial frame collector.
package frame_pkg;

    localparam int unsigned FRAME_W = 15;
    localparam int unsigned LEN_W   = 4;

    typedef logic [FRAME_W-1:0] frame_t;
    typedef logic [LEN_W-1:0]   len_t;

    typedef enum logic [1:0] {
        COLLECT    = 2'd0,
        FULL       = 2'd1,
        FLUSH_WAIT = 2'd2
    } coll_state_t;

    localparam len_t FRAME_LEN = LEN_W'(FRAME_W);

endpackage

// File: rtl/frame_popcount.sv
// Combinational ones counter over one frame; used for the optional frame_ones output.
module frame_popcount
    import frame_pkg::*;
(
    input  logic [FRAME_W-1:0] frame,
    output logic [LEN_W-1:0]   ones
);

    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < FRAME_W; i++) begin
            ones = ones + LEN_W'(frame[i]);
        end
    end

endmodule

// File: rtl/serial_frame_collector.sv
// Packs a serial valid/ready bit stream into FRAME_W-bit frames with a registered output hold.
// Optional FRAME_ONES_COUNT_EN adds a registered ones count of each emitted frame.
module serial_frame_collector
    import frame_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    input  logic               flush,
    output logic [FRAME_W-1:0] frame_out,
    output logic [LEN_W-1:0]   frame_len,
    output logic               frame_valid,
    input  logic               frame_ready,
`ifdef FRAME_ONES_COUNT_EN
    output logic [LEN_W-1:0]   frame_ones,
`endif
    output logic [LEN_W-1:0]   fill_cnt
);

    coll_state_t state, state_next;
    frame_t      shift_reg, shift_next;
    len_t        fill_next;
    frame_t      out_next;
    len_t        len_next;
    logic        valid_next;
    logic        ready_next;

    logic        hold_free;
    logic        accept;
    frame_t      acc_shift;
    len_t        acc_fill;
    logic        load;
    frame_t      load_data;
    len_t        load_len;

    // Next-state, shift register and hold register update.
    always_comb begin
        state_next = state;
        fill_next  = fill_cnt;
        shift_next = shift_reg;
        out_next   = frame_out;
        len_next   = frame_len;
        valid_next = frame_valid && !frame_ready;
        load       = 1'b0;
        load_data  = shift_reg;
        load_len   = fill_cnt;

        hold_free  = !frame_valid || frame_ready;
        accept     = bit_valid && bit_ready;
        acc_shift  = shift_reg | (FRAME_W'(bit_in && accept) << fill_cnt);
        acc_fill   = fill_cnt + LEN_W'(accept);

        case (state)
            COLLECT: begin
                shift_next = acc_shift;
                fill_next  = acc_fill;
                // A flush with nothing collected and no bit this cycle is a no-op.
                if ((accept && acc_fill == FRAME_LEN) || (flush && acc_fill != '0)) begin
                    if (hold_free) begin
                        load      = 1'b1;
                        load_data = acc_shift;
                        load_len  = acc_fill;
                    end else begin
                        state_next = (acc_fill == FRAME_LEN) ? FULL : FLUSH_WAIT;
                    end
                end
            end
            FULL, FLUSH_WAIT: begin
                if (hold_free) begin
                    load       = 1'b1;
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase

        // Clearing the shift register on transfer keeps later partial frames zero-padded.
        if (load) begin
            out_next   = load_data;
            len_next   = load_len;
            valid_next = 1'b1;
            fill_next  = '0;
            shift_next = '0;
        end

        ready_next = (state_next == COLLECT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= COLLECT;
            fill_cnt    <= '0;
            shift_reg   <= '0;
            frame_out   <= '0;
            frame_len   <= '0;
            frame_valid <= 1'b0;
            bit_ready   <= 1'b0;
        end else begin
            state       <= state_next;
            fill_cnt    <= fill_next;
            shift_reg   <= shift_next;
            frame_out   <= out_next;
            frame_len   <= len_next;
            frame_valid <= valid_next;
            bit_ready   <= ready_next;
        end
    end

`ifdef FRAME_ONES_COUNT_EN
    len_t ones_c;

    frame_popcount u_popcount (
        .frame (load_data),
        .ones  (ones_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_ones <= '0;
        end else if (load) begin
            frame_ones <= ones_c;
        end
    end
`endif

endmodule

// File: tb/tb_serial_frame_collector.sv
// Directed self-checking bench for serial_frame_collector (define FRAME_ONES_COUNT_EN to cover frame_ones).
module tb_serial_frame_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic        flush;
    logic [14:0] frame_out;
    logic [3:0]  frame_len;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  fill_cnt;
`ifdef FRAME_ONES_COUNT_EN
    logic [3:0]  frame_ones;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_frame_collector dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .flush       (flush),
        .frame_out   (frame_out),
        .frame_len   (frame_len),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
`ifdef FRAME_ONES_COUNT_EN
        .frame_ones  (frame_ones),
`endif
        .fill_cnt    (fill_cnt)
    );

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; frame_ready = 1'b0;
        step(); step();
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", frame_valid); end
        checks++; if (bit_ready !== 1'b0) begin failures++; $display("FAIL reset_bit_ready got=%0b exp=0", bit_ready); end
        checks++; if (fill_cnt !== 4'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_cnt); end
        checks++; if (frame_out !== 15'h0000) begin failures++; $display("FAIL reset_out got=%h exp=0000", frame_out); end
        checks++; if (frame_len !== 4'd0) begin failures++; $display("FAIL reset_len got=%0d exp=0", frame_len); end
`ifdef FRAME_ONES_COUNT_EN
        checks++; if (frame_ones !== 4'd0) begin failures++; $display("FAIL reset_ones got=%0d exp=0", frame_ones); end
`endif
        rst = 1'b0;
        step();
        checks++; if (bit_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%0b exp=1", bit_ready); end

        // Seven bits, then an asynchronous reset between edges.
        frame_ready = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        repeat (7) step();
        checks++; if (fill_cnt !== 4'd7) begin failures++; $display("FAIL mid_fill got=%0d exp=7", fill_cnt); end
        bit_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (fill_cnt !== 4'd0) begin failures++; $display("FAIL async_fill got=%0d exp=0", fill_cnt); end
        checks++; if (bit_ready !== 1'b0) begin failures++; $display("FAIL async_ready got=%0b exp=0", bit_ready); end
        step();
        rst = 1'b0;
        step();
        checks++; if (bit_ready !== 1'b1) begin failures++; $display("FAIL rerelease_ready got=%0b exp=1", bit_ready); end

        for (int k = 0; k < 15; k++) begin
            bit_in = (k % 2 == 0);
            bit_valid = 1'b1;
            step();
            if (k < 14) begin
                checks++;
                if (frame_valid !== 1'b0) begin failures++; $display("FAIL stale_frame k=%0d got=%0b exp=0", k, frame_valid); end
            end
        end
        bit_valid = 1'b0;
        checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL alt_valid got=%0b exp=1", frame_valid); end
        checks++; if (frame_out !== 15'h5555) begin failures++; $display("FAIL alt_out got=%h exp=5555", frame_out); end
        checks++; if (frame_len !== 4'd15) begin failures++; $display("FAIL alt_len got=%0d exp=15", frame_len); end
        checks++; if (fill_cnt !== 4'd0) begin failures++; $display("FAIL alt_fill got=%0d exp=0", fill_cnt); end
        step();
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL alt_drain got=%0b exp=0", frame_valid); end
    endtask

    task automatic test_stream();
        logic [14:0] exp_frames [3];
        logic [3:0]  exp_ones [3];
        int frames;
        logic pulse;
        exp_frames[0] = 15'h7FFF; exp_frames[1] = 15'h0000; exp_frames[2] = 15'h2AAA;
        exp_ones[0] = 4'd15; exp_ones[1] = 4'd0; exp_ones[2] = 4'd7;
        frames = 0;
        frame_ready = 1'b1;
        for (int i = 0; i < 45; i++) begin
            bit_in = (i < 15) ? 1'b1 : (i < 30) ? 1'b0 : 1'(i % 2);
            bit_valid = 1'b1;
            step();
            pulse = ((i + 1) % 15 == 0);
            checks++; if (bit_ready !== 1'b1) begin failures++; $display("FAIL stream_ready i=%0d got=%0b exp=1", i, bit_ready); end
            checks++; if (frame_valid !== pulse) begin failures++; $display("FAIL stream_valid i=%0d got=%0b exp=%0b", i, frame_valid, pulse); end
            if (frame_valid === 1'b1 && frames < 3) begin
                checks++; if (frame_out !== exp_frames[frames]) begin failures++; $display("FAIL stream_out f=%0d got=%h exp=%h", frames, frame_out, exp_frames[frames]); end
                checks++; if (frame_len !== 4'd15) begin failures++; $display("FAIL stream_len f=%0d got=%0d exp=15", frames, frame_len); end
`ifdef FRAME_ONES_COUNT_EN
                checks++; if (frame_ones !== exp_ones[frames]) begin failures++; $display("FAIL stream_ones f=%0d got=%0d exp=%0d", frames, frame_ones, exp_ones[frames]); end
`endif
                frames++;
            end
        end
        bit_valid = 1'b0;
        checks++; if (frames !== 3) begin failures++; $display("FAIL stream_frames got=%0d exp=3", frames); end
        step();
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0b exp=0", frame_valid); end
    endtask

    task automatic test_back_to_back();
        frame_ready = 1'b0;
        bit_in = 1'b1; bit_valid = 1'b1;
        repeat (15) step();
        checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL bp_first_valid got=%0b exp=1", frame_valid); end
        for (int k = 0; k < 15; k++) begin
            bit_in = (k < 4);
            step();
        end
        checks++; if (fill_cnt !== 4'd15) begin failures++; $display("FAIL bp_full_fill got=%0d exp=15", fill_cnt); end
        checks++; if (bit_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%0b exp=0", bit_ready); end
        checks++; if (frame_out !== 15'h7FFF) begin failures++; $display("FAIL bp_held_out got=%h exp=7fff", frame_out); end
        bit_in = 1'b1;
        step();
        checks++; if (fill_cnt !== 4'd15) begin failures++; $display("FAIL bp_blocked_fill got=%0d exp=15", fill_cnt); end
        bit_valid = 1'b0; frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        checks++; if (frame_out !== 15'h000F) begin failures++; $display("FAIL bp_second_out got=%h exp=000f", frame_out); end
        checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL bp_second_valid got=%0b exp=1", frame_valid); end
        checks++; if (bit_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%0b exp=1", bit_ready); end
        checks++; if (fill_cnt !== 4'd0) begin failures++; $display("FAIL bp_fill_clear got=%0d exp=0", fill_cnt); end
        step();
        checks++; if (frame_valid !== 1'b1 || frame_out !== 15'h000F) begin failures++; $display("FAIL bp_stable got=%0b/%h exp=1/000f", frame_valid, frame_out); end
        frame_ready = 1'b1;
        step();
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", frame_valid); end
    endtask

    task automatic test_flush();
        frame_ready = 1'b1;
        bit_in = 1'b1; bit_valid = 1'b1;
        repeat (3) step();
        checks++; if (fill_cnt !== 4'd3) begin failures++; $display("FAIL fl_fill got=%0d exp=3", fill_cnt); end
        bit_valid = 1'b0; flush = 1'b1;
        step();
        checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL fl_valid got=%0b exp=1", frame_valid); end
        checks++; if (frame_out !== 15'h0007) begin failures++; $display("FAIL fl_out got=%h exp=0007", frame_out); end
        checks++; if (frame_len !== 4'd3) begin failures++; $display("FAIL fl_len got=%0d exp=3", frame_len); end
        checks++; if (fill_cnt !== 4'd0) begin failures++; $display("FAIL fl_fill_clear got=%0d exp=0", fill_cnt); end
        step();
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL fl_empty_ignored got=%0b exp=0", frame_valid); end
        flush = 1'b0;
        step();
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL fl_idle got=%0b exp=0", frame_valid); end
    endtask

    task automatic test_flush_wait();
        frame_ready = 1'b0;
        bit_in = 1'b1; bit_valid = 1'b1;
        repeat (2) step();
        bit_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (frame_out !== 15'h0003 || frame_len !== 4'd2) begin failures++; $display("FAIL fw_first got=%h/%0d exp=0003/2", frame_out, frame_len); end
        bit_in = 1'b0; bit_valid = 1'b1;
        repeat (4) step();
        bit_in = 1'b1; flush = 1'b1;
        step();
        bit_valid = 1'b0;
        checks++; if (fill_cnt !== 4'd5) begin failures++; $display("FAIL fw_fill got=%0d exp=5", fill_cnt); end
        checks++; if (bit_ready !== 1'b0) begin failures++; $display("FAIL fw_ready got=%0b exp=0", bit_ready); end
        checks++; if (frame_out !== 15'h0003 || frame_len !== 4'd2) begin failures++; $display("FAIL fw_held got=%h/%0d exp=0003/2", frame_out, frame_len); end
        step();
        flush = 1'b0;
        checks++; if (fill_cnt !== 4'd5 || frame_len !== 4'd2) begin failures++; $display("FAIL fw_reflush got=%0d/%0d exp=5/2", fill_cnt, frame_len); end
        frame_ready = 1'b1;
        step();
        checks++; if (frame_out !== 15'h0010) begin failures++; $display("FAIL fw_out got=%h exp=0010", frame_out); end
        checks++; if (frame_len !== 4'd5) begin failures++; $display("FAIL fw_len got=%0d exp=5", frame_len); end
        checks++; if (frame_valid !== 1'b1 || bit_ready !== 1'b1 || fill_cnt !== 4'd0) begin failures++; $display("FAIL fw_release got=%0b/%0b/%0d exp=1/1/0", frame_valid, bit_ready, fill_cnt); end
`ifdef FRAME_ONES_COUNT_EN
        checks++; if (frame_ones !== 4'd1) begin failures++; $display("FAIL fw_ones got=%0d exp=1", frame_ones); end
`endif
        step();
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL fw_drain got=%0b exp=0", frame_valid); end

        // Flush while FULL must not disturb the committed frame.
        frame_ready = 1'b0;
        bit_in = 1'b1; bit_valid = 1'b1;
        repeat (30) step();
        bit_valid = 1'b0;
        checks++; if (fill_cnt !== 4'd15 || bit_ready !== 1'b0) begin failures++; $display("FAIL full_state got=%0d/%0b exp=15/0", fill_cnt, bit_ready); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (fill_cnt !== 4'd15 || bit_ready !== 1'b0) begin failures++; $display("FAIL full_flush got=%0d/%0b exp=15/0", fill_cnt, bit_ready); end
        frame_ready = 1'b1;
        step();
        checks++; if (frame_valid !== 1'b1 || frame_len !== 4'd15 || fill_cnt !== 4'd0) begin failures++; $display("FAIL full_release got=%0b/%0d/%0d exp=1/15/0", frame_valid, frame_len, fill_cnt); end
        step();
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL full_drain got=%0b exp=0", frame_valid); end
    endtask

`ifdef FRAME_ONES_COUNT_EN
    task automatic test_ones_count();
        frame_ready = 1'b1;
        bit_in = 1'b1; bit_valid = 1'b1;
        repeat (15) step();
        checks++; if (frame_ones !== 4'd15) begin failures++; $display("FAIL ones_all got=%0d exp=15", frame_ones); end
        bit_in = 1'b0;
        repeat (15) step();
        checks++; if (frame_ones !== 4'd0) begin failures++; $display("FAIL ones_none got=%0d exp=0", frame_ones); end
        bit_in = 1'b1;
        repeat (3) step();
        bit_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (frame_ones !== 4'd3 || frame_len !== 4'd3) begin failures++; $display("FAIL ones_partial got=%0d/%0d exp=3/3", frame_ones, frame_len); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_flush();
        test_flush_wait();
`ifdef FRAME_ONES_COUNT_EN
        test_ones_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
